// File: rtl/my_alu1.sv
// my_alu1 -- 16-bit registered arithmetic/logic unit.
//
// Applies one of eight operations to two 16-bit operands and a carry/fill
// bit, and registers the result together with zero/negative status flags
// on the rising clock edge (one-cycle latency, one operation per cycle).
//
// Ports:
//   clk  in   1   rising-edge clock
//   rst  in   1   asynchronous, active-high reset
//   inA  in   16  operand A
//   inB  in   16  operand B
//   inC  in   1   carry-in for ADD/SUB, fill bit for SHL/SHR
//   opc  in   3   operation select
//   w    out  16  registered result
//   zer  out  1   registered zero flag (w == 0)
//   neg  out  1   registered negative flag (w[15])
//
// Build option:
//   MYALU1_SAT_EN  when defined, ADD and SUB clamp to the signed 16-bit range
//                  (7FFF / 8000) instead of wrapping modulo 2^16.

module my_alu1 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inA,
    input  logic [15:0] inB,
    input  logic        inC,
    input  logic [2:0]  opc,
    output logic [15:0] w,
    output logic        zer,
    output logic        neg
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } opcode_e;

    logic [15:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        negFlag_q, negFlag_d;

    logic [15:0] addResult;
    logic [15:0] subResult;

`ifdef MYALU1_SAT_EN
    // Sign-extend to 18 bits so the exact signed sum/difference (including
    // the carry) fits; bits [17:15] disagreeing means the value left the
    // signed 16-bit range, and bit 17 tells which side it left on.
    logic [17:0] addWide;
    logic [17:0] subWide;

    function automatic logic [15:0] satClamp(input logic [17:0] v);
        if (v[17:15] == 3'b000 || v[17:15] == 3'b111) begin
            return v[15:0];
        end else if (!v[17]) begin
            return 16'h7FFF;
        end else begin
            return 16'h8000;
        end
    endfunction

    always_comb begin
        addWide   = {{2{inA[15]}}, inA} + {{2{inB[15]}}, inB} + {17'd0, inC};
        subWide   = {{2{inA[15]}}, inA} - {{2{inB[15]}}, inB} - {17'd0, inC};
        addResult = satClamp(addWide);
        subResult = satClamp(subWide);
    end
`else
    // Plain modulo-2^16 arithmetic; subtraction is A + ~B + ~inC, which
    // equals A - B - inC in two's complement.
    always_comb begin
        addResult = inA + inB + {15'd0, inC};
        subResult = inA + ~inB + {15'd0, ~inC};
    end
`endif

    // Result select; flags are derived from the selected value so they
    // always agree with what lands in w.
    always_comb begin
        result_d = 16'h0000;
        case (opcode_e'(opc))
            OP_ADD:  result_d = addResult;
            OP_SUB:  result_d = subResult;
            OP_AND:  result_d = inA & inB;
            OP_OR:   result_d = inA | inB;
            OP_XOR:  result_d = inA ^ inB;
            OP_NOT:  result_d = ~inA;
            OP_SHL:  result_d = {inA[14:0], inC};
            OP_SHR:  result_d = {inC, inA[15:1]};
            default: result_d = 16'h0000;
        endcase
        zero_d    = (result_d == 16'h0000);
        negFlag_d = result_d[15];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= 16'h0000;
            zero_q    <= 1'b1;
            negFlag_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            negFlag_q <= negFlag_d;
        end
    end

    assign w   = result_q;
    assign zer = zero_q;
    assign neg = negFlag_q;

endmodule

// File: tb/tb_my_alu1.sv
// tb_my_alu1 -- directed and randomized checks for my_alu1.
//
// Drives inputs right after a rising edge, samples outputs 1 ns after the
// next rising edge, and compares against hand-computed constants or a
// small independent reference model (random sweep).

module tb_my_alu1;

    logic        clk;
    logic        rst;
    logic [15:0] inA;
    logic [15:0] inB;
    logic        inC;
    logic [2:0]  opc;
    logic [15:0] w;
    logic        zer;
    logic        neg;

    int checks;
    int failures;

    my_alu1 dut (
        .clk (clk),
        .rst (rst),
        .inA (inA),
        .inB (inB),
        .inC (inC),
        .opc (opc),
        .w   (w),
        .zer (zer),
        .neg (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written from the operation table, using signed
    // integer arithmetic for the saturating build.
    function automatic logic [15:0] modelAlu(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic c);
        int sa;
        int sb;
        int s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            3'b000: s = sa + sb + int'(c);
            3'b001: s = sa - sb - int'(c);
            default: s = 0;
        endcase
`ifdef MYALU1_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        case (op)
            3'b000, 3'b001: return s[15:0];
            3'b010: return a & b;
            3'b011: return a | b;
            3'b100: return a ^ b;
            3'b101: return ~a;
            3'b110: return {a[14:0], c};
            default: return {c, a[15:1]};
        endcase
    endfunction

    // Present one operation and wait until it has been registered.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic c);
        opc = op;
        inA = a;
        inB = b;
        inC = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] expW,
                               input logic expZ, input logic expN);
        checks++;
        assert (w === expW) else begin
            failures++;
            $error("[TB] FAIL %s.w observed=%h expected=%h", tag, w, expW);
        end
        checks++;
        assert (zer === expZ) else begin
            failures++;
            $error("[TB] FAIL %s.zer observed=%b expected=%b", tag, zer, expZ);
        end
        checks++;
        assert (neg === expN) else begin
            failures++;
            $error("[TB] FAIL %s.neg observed=%b expected=%b", tag, neg, expN);
        end
    endtask

    initial begin
        logic [15:0] expW;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [2:0]  rop;

        checks   = 0;
        failures = 0;
        rst = 1'b0;
        inA = 16'hA5A5;
        inB = 16'h5A5A;
        inC = 1'b1;
        opc = 3'b011;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 checkOutput("reset_async", 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(3'b000, 16'h0001, 16'h0002, 1'b1);
        checkOutput("add_first", 16'h0004, 1'b0, 1'b0);

        applyStimulus(3'b000, 16'hFFFF, 16'h0001, 1'b0);
        checkOutput("add_wrap_zero", 16'h0000, 1'b1, 1'b0);

        applyStimulus(3'b000, 16'h7FFF, 16'h0001, 1'b0);
`ifdef MYALU1_SAT_EN
        checkOutput("add_pos_ovf", 16'h7FFF, 1'b0, 1'b0);
`else
        checkOutput("add_pos_ovf", 16'h8000, 1'b0, 1'b1);
`endif

        applyStimulus(3'b001, 16'h0003, 16'h0005, 1'b0);
        checkOutput("sub_neg", 16'hFFFE, 1'b0, 1'b1);

        applyStimulus(3'b001, 16'h0003, 16'h0005, 1'b1);
        checkOutput("sub_borrow", 16'hFFFD, 1'b0, 1'b1);

        applyStimulus(3'b001, 16'h8000, 16'h0001, 1'b0);
`ifdef MYALU1_SAT_EN
        checkOutput("sub_neg_ovf", 16'h8000, 1'b0, 1'b1);
`else
        checkOutput("sub_neg_ovf", 16'h7FFF, 1'b0, 1'b0);
`endif

        applyStimulus(3'b001, 16'h0005, 16'h0005, 1'b0);
        checkOutput("sub_zero", 16'h0000, 1'b1, 1'b0);

        applyStimulus(3'b010, 16'hF0F0, 16'h3C3C, 1'b0);
        checkOutput("and", 16'h3030, 1'b0, 1'b0);

        applyStimulus(3'b011, 16'hF0F0, 16'h3C3C, 1'b0);
        checkOutput("or", 16'hFCFC, 1'b0, 1'b1);

        applyStimulus(3'b100, 16'hF0F0, 16'h3C3C, 1'b0);
        checkOutput("xor", 16'hCCCC, 1'b0, 1'b1);

        applyStimulus(3'b101, 16'hF0F0, 16'h3C3C, 1'b1);
        checkOutput("not", 16'h0F0F, 1'b0, 1'b0);

        applyStimulus(3'b110, 16'h8001, 16'h0000, 1'b1);
        checkOutput("shl_fill1", 16'h0003, 1'b0, 1'b0);

        applyStimulus(3'b111, 16'h8001, 16'h0000, 1'b0);
        checkOutput("shr_fill0", 16'h4000, 1'b0, 1'b0);

        applyStimulus(3'b111, 16'h8001, 16'h0000, 1'b1);
        checkOutput("shr_fill1", 16'hC000, 1'b0, 1'b1);

        // Inputs changing between edges must not disturb the outputs.
        @(negedge clk);
        opc = 3'b000;
        inA = 16'h0001;
        inB = 16'h0001;
        inC = 1'b0;
        #1 checkOutput("hold_between_edges", 16'hC000, 1'b0, 1'b1);
        @(posedge clk);
        #1 checkOutput("hold_next_edge", 16'h0002, 1'b0, 1'b0);

        // Random sweep with a mid-run asynchronous reset.
        for (int i = 0; i < 64; i++) begin
            rop = 3'(i);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom);
            applyStimulus(rop, ra, rb, rc);
            expW = modelAlu(rop, ra, rb, rc);
            checkOutput($sformatf("sweep%0d_op%0d", i, rop), expW,
                        (expW == 16'h0000), expW[15]);
            if (i == 40) begin
                #2 rst = 1'b1;
                #1 checkOutput("reset_midrun", 16'h0000, 1'b1, 1'b0);
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
